// File: rtl/acl_frame_gate.sv
// Store-and-forward ACL gate: frames are buffered uncommitted until the permit/deny verdict; first word out 3 cycles after a tlast carrying its verdict.
// Backpressure: input stalls only while awaiting a verdict; the forward port holds its word while i_fwd_tready is low.
module acl_frame_gate #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_rxd_tdata,
    input  logic                  i_rxd_tvalid,
    input  logic                  i_rxd_tlast,
    output logic                  o_rxd_tready,
    input  logic                  i_decision_valid,
    input  logic                  i_deny_data,
    output logic [DATA_WIDTH-1:0] o_fwd_tdata,
    output logic                  o_fwd_tvalid,
    output logic                  o_fwd_tlast,
    input  logic                  i_fwd_tready,
    output logic [CNT_WIDTH-1:0]  o_pass_count,
    output logic [CNT_WIDTH-1:0]  o_drop_count
);

    localparam int                    DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   FULL_P  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RECV, WAIT_DEC, DISCARD} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_tent_q, wr_tent_d;
    logic [ADDR_WIDTH:0]   wr_commit_q, wr_commit_d;
    logic [ADDR_WIDTH:0]   rd_q;
    logic                  dec_vld_q, dec_vld_d;
    logic                  dec_deny_q, dec_deny_d;
    logic                  rdy_en_q;
    logic [CNT_WIDTH-1:0]  pass_q, drop_q;
    logic                  pass_inc, drop_inc, wr_en, verdict_deny;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [DATA_WIDTH:0]   s1_dat_q;
    logic                  s1_vld_q;
    logic [DATA_WIDTH-1:0] fwd_dat_q;
    logic                  fwd_vld_q, fwd_last_q;
    logic                  out_adv, rd_en, full, in_xfer;

    assign full         = (wr_tent_q - rd_q) == FULL_P;
    assign o_rxd_tready = rdy_en_q & (state_q != WAIT_DEC);
    assign in_xfer      = i_rxd_tvalid & o_rxd_tready;

    always_comb begin
        state_d      = state_q;
        wr_tent_d    = wr_tent_q;
        wr_commit_d  = wr_commit_q;
        dec_vld_d    = dec_vld_q;
        dec_deny_d   = dec_deny_q;
        wr_en        = 1'b0;
        pass_inc     = 1'b0;
        drop_inc     = 1'b0;
        verdict_deny = dec_deny_q;
        // Verdicts seen before the frame ends are held and applied at frame end.
        if (i_decision_valid && state_q != WAIT_DEC) begin
            dec_vld_d  = 1'b1;
            dec_deny_d = i_deny_data;
        end
        case (state_q)
            IDLE, RECV: begin
                if (in_xfer) begin
                    if (full) begin
                        if (i_rxd_tlast) begin
                            wr_tent_d = wr_commit_q;
                            drop_inc  = 1'b1;
                            dec_vld_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else begin
                        wr_en     = 1'b1;
                        wr_tent_d = wr_tent_q + PTR_ONE;
                        state_d   = i_rxd_tlast ? WAIT_DEC : RECV;
                    end
                end
            end
            DISCARD: begin
                if (in_xfer && i_rxd_tlast) begin
                    wr_tent_d = wr_commit_q;
                    drop_inc  = 1'b1;
                    dec_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WAIT_DEC: begin
                if (i_decision_valid || dec_vld_q) begin
                    verdict_deny = i_decision_valid ? i_deny_data : dec_deny_q;
                    if (verdict_deny) begin
                        wr_tent_d = wr_commit_q;
                        drop_inc  = 1'b1;
                    end else begin
                        wr_commit_d = wr_tent_q;
                        pass_inc    = 1'b1;
                    end
                    dec_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-stage read: RAM output register (s1) then the forward register.
    assign out_adv = ~fwd_vld_q | i_fwd_tready;
    assign rd_en   = (rd_q != wr_commit_q) & (~s1_vld_q | out_adv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_tent_q   <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
            dec_vld_q   <= 1'b0;
            dec_deny_q  <= 1'b0;
            rdy_en_q    <= 1'b0;
            pass_q      <= '0;
            drop_q      <= '0;
            s1_vld_q    <= 1'b0;
            fwd_vld_q   <= 1'b0;
            fwd_dat_q   <= '0;
            fwd_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_tent_q   <= wr_tent_d;
            wr_commit_q <= wr_commit_d;
            dec_vld_q   <= dec_vld_d;
            dec_deny_q  <= dec_deny_d;
            rdy_en_q    <= 1'b1;
            if (pass_inc && pass_q != '1) pass_q <= pass_q + CNT_ONE;
            if (drop_inc && drop_q != '1) drop_q <= drop_q + CNT_ONE;
            if (rd_en) rd_q <= rd_q + PTR_ONE;
            s1_vld_q <= rd_en | (s1_vld_q & ~out_adv);
            if (out_adv) begin
                fwd_vld_q <= s1_vld_q;
                if (s1_vld_q) {fwd_last_q, fwd_dat_q} <= s1_dat_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_tent_q[ADDR_WIDTH-1:0]] <= {i_rxd_tlast, i_rxd_tdata};
        if (rd_en) s1_dat_q <= mem[rd_q[ADDR_WIDTH-1:0]];
    end

    assign o_fwd_tdata  = fwd_dat_q;
    assign o_fwd_tvalid = fwd_vld_q;
    assign o_fwd_tlast  = fwd_last_q;
    assign o_pass_count = pass_q;
    assign o_drop_count = drop_q;

endmodule
